// File: rtl/mask_splitter.sv
// Splits a request mask into the indices of its set bits, lowest first,
// handing out one index per valid/ready handshake.
module mask_splitter #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic [CNTW-1:0]  out_cnt,
    output logic             zero_drop
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] rem_clr;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == SCAN);

    // Clearing the lowest set bit of rem yields the remaining work after a beat.
    assign rem_clr  = rem & (rem - WIDTH'(1));
    assign out_last = (rem != '0) && (rem_clr == '0);

    // NOTE: default assignment first so the encoder cannot infer a latch.
    always_comb begin
        out_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rem[i]) begin
                out_idx = IDXW'(i);
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every register
    // samples the pre-edge values and update order does not matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rem       <= '0;
            out_cnt   <= '0;
            zero_drop <= 1'b0;
        end else begin
            zero_drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_mask != '0) begin
                            rem     <= in_mask;
                            out_cnt <= '0;
                            state   <= SCAN;
                        end else begin
                            zero_drop <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        rem     <= rem_clr;
                        out_cnt <= out_cnt + CNTW'(1);
                        if (out_last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mask_splitter.sv
// Directed and randomized checks of mask_splitter index streaming,
// back-pressure, zero-mask drop, back-to-back masks and mid-scan reset.
module tb_mask_splitter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_mask = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_idx;
    logic        out_last;
    logic [5:0]  out_cnt;
    logic        zero_drop;

    int n_vec = 0;
    int n_err = 0;

    mask_splitter #(.WIDTH(32), .IDXW(5), .CNTW(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_cnt   (out_cnt),
        .zero_drop (zero_drop)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a mask for one accepting edge, waiting a bounded time for in_ready.
    task automatic accept(input logic [31:0] mask);
        int budget = 100;
        while (!in_ready && budget > 0) begin
            tick();
            budget--;
        end
        n_vec++;
        if (!in_ready) begin
            $display("FAIL accept_wait: in_ready=%0b required 1", in_ready);
            n_err++;
        end
        in_valid = 1'b1;
        in_mask  = mask;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_vec++;
        if ({in_ready, out_valid, out_last, zero_drop} !== 4'b1000 ||
            out_cnt !== 6'd0 || out_idx !== 5'd0) begin
            $display("FAIL reset: rdy=%0b vld=%0b last=%0b zd=%0b cnt=%0d idx=%0d required 1 0 0 0 0 0",
                     in_ready, out_valid, out_last, zero_drop, out_cnt, out_idx);
            n_err++;
        end
    endtask

    task automatic test_basic();
        logic [4:0] exp_idx [3] = '{5'd0, 5'd4, 5'd31};
        out_ready = 1'b1;
        accept(32'h8000_0011);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_idx !== exp_idx[i] || out_cnt !== 6'(i) ||
                out_last !== (i == 2) || in_ready !== 1'b0) begin
                $display("FAIL basic[%0d]: vld=%0b idx=%0d cnt=%0d last=%0b rdy=%0b required 1 %0d %0d %0b 0",
                         i, out_valid, out_idx, out_cnt, out_last, in_ready, exp_idx[i], i, i == 2);
                n_err++;
            end
            tick();
        end
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL basic_done: rdy=%0b vld=%0b required 1 0", in_ready, out_valid);
            n_err++;
        end
    endtask

    task automatic test_backpressure();
        logic       rdy  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [4:0] idx  [5] = '{5'd1, 5'd1, 5'd1, 5'd2, 5'd2};
        logic       last [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [5:0] cnt  [5] = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd1};
        out_ready = 1'b0;
        accept(32'h0000_0006);
        for (int i = 0; i < 5; i++) begin
            out_ready = rdy[i];
            n_vec++;
            if (out_valid !== 1'b1 || out_idx !== idx[i] || out_last !== last[i] ||
                out_cnt !== cnt[i]) begin
                $display("FAIL bp[%0d]: vld=%0b idx=%0d last=%0b cnt=%0d required 1 %0d %0b %0d",
                         i, out_valid, out_idx, out_last, out_cnt, idx[i], last[i], cnt[i]);
                n_err++;
            end
            tick();
        end
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_cnt !== 6'd2) begin
            $display("FAIL bp_done: rdy=%0b vld=%0b cnt=%0d required 1 0 2",
                     in_ready, out_valid, out_cnt);
            n_err++;
        end
    endtask

    task automatic test_zero();
        accept(32'h0);
        n_vec++;
        if (zero_drop !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL zero_pulse: zd=%0b vld=%0b rdy=%0b required 1 0 1",
                     zero_drop, out_valid, in_ready);
            n_err++;
        end
        tick();
        n_vec++;
        if (zero_drop !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL zero_after: zd=%0b vld=%0b rdy=%0b required 0 0 1",
                     zero_drop, out_valid, in_ready);
            n_err++;
        end
    endtask

    task automatic test_full();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mask   = 32'hFFFF_FFFF;
        tick();
        in_mask = 32'h0000_0001;  // must be ignored while scanning
        for (int i = 0; i < 32; i++) begin
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_idx !== 5'(i) ||
                out_cnt !== 6'(i) || out_last !== (i == 31)) begin
                $display("FAIL full[%0d]: vld=%0b rdy=%0b idx=%0d cnt=%0d last=%0b required 1 0 %0d %0d %0b",
                         i, out_valid, in_ready, out_idx, out_cnt, out_last, i, i, i == 31);
                n_err++;
            end
            tick();
        end
        in_valid = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_cnt !== 6'd32) begin
            $display("FAIL full_done: rdy=%0b vld=%0b cnt=%0d required 1 0 32",
                     in_ready, out_valid, out_cnt);
            n_err++;
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        accept(32'h0000_0003);
        tick();
        n_vec++;
        if (out_idx !== 5'd1 || out_last !== 1'b1) begin
            $display("FAIL b2b_first_last: idx=%0d last=%0b required 1 1", out_idx, out_last);
            n_err++;
        end
        tick();
        n_vec++;
        if (in_ready !== 1'b1) begin
            $display("FAIL b2b_ready: rdy=%0b required 1", in_ready);
            n_err++;
        end
        in_valid = 1'b1;
        in_mask  = 32'h0000_0100;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || out_idx !== 5'd8 || out_last !== 1'b1 || out_cnt !== 6'd0) begin
            $display("FAIL b2b_second: vld=%0b idx=%0d last=%0b cnt=%0d required 1 8 1 0",
                     out_valid, out_idx, out_last, out_cnt);
            n_err++;
        end
        tick();
    endtask

    task automatic test_reset_midscan();
        out_ready = 1'b1;
        accept(32'h0000_00F0);
        tick();
        tick();
        n_vec++;
        if (out_idx !== 5'd6 || out_cnt !== 6'd2) begin
            $display("FAIL mid_pre: idx=%0d cnt=%0d required 6 2", out_idx, out_cnt);
            n_err++;
        end
        rst = 1'b1;  // coincides with a handshake; reset must win
        tick();
        rst = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_cnt !== 6'd0) begin
            $display("FAIL mid_reset: vld=%0b rdy=%0b cnt=%0d required 0 1 0",
                     out_valid, in_ready, out_cnt);
            n_err++;
        end
        accept(32'h0000_0001);
        n_vec++;
        if (out_valid !== 1'b1 || out_idx !== 5'd0 || out_last !== 1'b1 || out_cnt !== 6'd0) begin
            $display("FAIL mid_new: vld=%0b idx=%0d last=%0b cnt=%0d required 1 0 1 0",
                     out_valid, out_idx, out_last, out_cnt);
            n_err++;
        end
        tick();
    endtask

    task automatic test_random();
        for (int m = 0; m < 1000; m++) begin
            logic [31:0] mask;
            int          exp_q [$];
            int          k;
            int          budget;
            mask = $urandom();
            case ($urandom_range(0, 3))
                0: mask = mask & $urandom() & $urandom();
                1: mask = (m % 10 == 0) ? 32'h0 : (32'h1 << $urandom_range(0, 31));
                default: ;
            endcase
            exp_q.delete();
            for (int b = 0; b < 32; b++) begin
                if (mask[b]) exp_q.push_back(b);
            end
            accept(mask);
            if (mask == 32'h0) begin
                n_vec++;
                if (zero_drop !== 1'b1 || out_valid !== 1'b0) begin
                    $display("FAIL rnd_zero[%0d]: zd=%0b vld=%0b required 1 0", m, zero_drop, out_valid);
                    n_err++;
                end
                continue;
            end
            k = 0;
            budget = 400;
            while (k < exp_q.size() && budget > 0) begin
                out_ready = 1'($urandom_range(0, 1));
                n_vec++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_idx !== 5'(exp_q[k]) ||
                    out_cnt !== 6'(k) || out_last !== (k == exp_q.size() - 1)) begin
                    $display("FAIL rnd[%0d.%0d]: vld=%0b rdy=%0b idx=%0d cnt=%0d last=%0b required 1 0 %0d %0d %0b",
                             m, k, out_valid, in_ready, out_idx, out_cnt, out_last,
                             exp_q[k], k, k == exp_q.size() - 1);
                    n_err++;
                end
                if (out_ready) k++;
                tick();
                budget--;
            end
            n_vec++;
            if (k != exp_q.size() || in_ready !== 1'b1 || out_valid !== 1'b0) begin
                $display("FAIL rnd_done[%0d]: beats=%0d rdy=%0b vld=%0b required %0d 1 0",
                         m, k, in_ready, out_valid, exp_q.size());
                n_err++;
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero();
        test_full();
        test_back_to_back();
        test_reset_midscan();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
